// File: rtl/iter_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Op codes, FSM states and a small op-class helper.
package iter_muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULU_LO = 2'b00,
    OP_MULU_HI = 2'b01,
    OP_DIVU    = 2'b10,
    OP_REMU    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_div(logic [1:0] o);
    return o[1];
  endfunction

endpackage

// File: rtl/iter_muldiv_if.sv
// Request/result bundle between the issuing stage and the muldiv unit.
// master issues start/op/operands, slave returns status and result.
interface iter_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/iter_muldiv_ctrl.sv
// Sequencer for iter_muldiv: IDLE/RUN/DONE FSM plus iteration counter.
// early (driven only when EARLY_OUT_EN is defined) skips RUN.
module iter_muldiv_ctrl
  import iter_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic early,
  output logic busy,
  output logic done,
  output logic step,
  output logic load,
  output logic fin
);

  state_e           state;
  state_e           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             last;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (load)
        cnt <= '0;
      else if (step)
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = early ? S_DONE : S_RUN;
      S_RUN:   if (last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
    step = busy;
    load = (state == S_IDLE) && start;
    fin  = busy && last;
  end

endmodule

// File: rtl/iter_muldiv.sv
// Iterative unsigned mul/div: shift-add multiply, restoring divide, 1 bit/clk.
// Define EARLY_OUT_EN to finish zero-operand cases straight from IDLE.
module iter_muldiv
  import iter_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  iter_muldiv_if.slave  bus
);

  logic busy, done, step, load, fin, early;

  op_e              op_r;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] nx_hi, nx_lo;
  logic [WIDTH:0]   sum, sh, diff;
  logic [WIDTH-1:0] res_nx;
  logic [WIDTH-1:0] result;
  logic             dbz;

  iter_muldiv_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .start (bus.start),
    .early (early),
    .busy  (busy),
    .done  (done),
    .step  (step),
    .load  (load),
    .fin   (fin)
  );

`ifdef EARLY_OUT_EN
  logic             a_z, b_z;
  logic [WIDTH-1:0] early_res;

  assign a_z   = (bus.a == '0);
  assign b_z   = (bus.b == '0);
  assign early = is_div(bus.op) ? b_z : (a_z | b_z);

  always_comb begin
    unique case (op_e'(bus.op))
      OP_DIVU: early_res = '1;
      OP_REMU: early_res = bus.a;
      default: early_res = '0;
    endcase
  end
`else
  assign early = 1'b0;
`endif

  // mul: {hi,lo} shifts right, lo starts as multiplier
  // div: {hi,lo} shifts left, hi is the partial remainder
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    sh   = {hi, lo[WIDTH-1]};
    diff = sh - {1'b0, opnd};
    if (is_div(op_r)) begin
      nx_hi = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
      nx_lo = {lo[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      nx_hi = sum[WIDTH:1];
      nx_lo = {sum[0], lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    unique case (op_r)
      OP_MULU_LO, OP_DIVU: res_nx = nx_lo;
      default:             res_nx = nx_hi;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r   <= OP_MULU_LO;
      opnd   <= '0;
      hi     <= '0;
      lo     <= '0;
      result <= '0;
      dbz    <= 1'b0;
    end else if (load) begin
      op_r <= op_e'(bus.op);
      opnd <= is_div(bus.op) ? bus.b : bus.a;
      hi   <= '0;
      lo   <= is_div(bus.op) ? bus.a : bus.b;
`ifdef EARLY_OUT_EN
      if (early) begin
        result <= early_res;
        dbz    <= is_div(bus.op);
      end
`endif
    end else if (step) begin
      hi <= nx_hi;
      lo <= nx_lo;
      if (fin) begin
        result <= res_nx;
        dbz    <= is_div(op_r) && (opnd == '0);
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.result      = result;
  assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_iter_muldiv.sv
// Randomized self-checking bench for iter_muldiv against an arithmetic model.
// Covers directed corner cases, ignored starts and async reset mid-operation.
module tb_iter_muldiv;

  logic        clk;
  logic        rst;
  logic [31:0] dreg;
  int          total;
  int          bad;

  iter_muldiv_if #(.WIDTH(32)) bus ();

  iter_muldiv #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.done) dreg <= bus.result;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(logic [1:0] o, logic [31:0] x,
                                          logic [31:0] y);
    logic [63:0] p;
    p = {32'b0, x} * {32'b0, y};
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (y == 0) ? 32'hFFFF_FFFF : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int exp_lat(logic [1:0] o, logic [31:0] x,
                                 logic [31:0] y);
`ifdef EARLY_OUT_EN
    if (o[1] ? (y == 0) : (x == 0 || y == 0)) return 0;
`endif
    return 32;
  endfunction

  task automatic wait_done(output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) nbusy++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [31:0] x, input logic [31:0] y);
    int          lat, nbusy, el;
    logic [31:0] er;
    er = ref_res(o, x, y);
    el = exp_lat(o, x, y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 2'($urandom_range(0, 3));
    bus.a     = $urandom;
    bus.b     = $urandom;
    wait_done(lat, nbusy);
    chk({tag, ".lat"}, 64'(lat), 64'(el));
    chk({tag, ".busy"}, 64'(nbusy), 64'(el));
    chk({tag, ".res"}, 64'(bus.result), 64'(er));
    chk({tag, ".dbz"}, 64'(bus.div_by_zero), 64'(o[1] && y == 0));
    @(posedge clk);
    #1;
    chk({tag, ".pulse"}, 64'(bus.done), 64'(0));
    chk({tag, ".dreg"}, 64'(dreg), 64'(er));
  endtask

  initial begin
    int          lat, nbusy, ndone;
    logic [1:0]  o;
    logic [31:0] x, y;
    total     = 0;
    bad       = 0;
    dreg      = '0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 64'(bus.busy), 64'(0));
    chk("rst.done", 64'(bus.done), 64'(0));
    chk("rst.res", 64'(bus.result), 64'(0));
    chk("rst.dbz", 64'(bus.div_by_zero), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    run_op("mullo7x6", 2'd0, 32'd7, 32'd6);
    run_op("mulhi_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mullo_ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div100_7", 2'd2, 32'd100, 32'd7);
    run_op("rem100_7", 2'd3, 32'd100, 32'd7);
    run_op("div5_9", 2'd2, 32'd5, 32'd9);
    run_op("rem5_9", 2'd3, 32'd5, 32'd9);
    run_op("div_b0", 2'd2, 32'h1234, 32'd0);
    run_op("rem_b0", 2'd3, 32'h1234, 32'd0);
    run_op("mul_a0", 2'd1, 32'd0, 32'h8000_0001);
    run_op("div_big", 2'd2, 32'hFFFF_FFFF, 32'h8000_0000);

    // starts during RUN and DONE must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'd2;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat, nbusy);
    chk("ign.lat", 64'(lat), 64'(27));
    chk("ign.res", 64'(bus.result), 64'(14));
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("ign.busy", 64'(bus.busy), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    chk("ign.idle", 64'({bus.busy, bus.done}), 64'(0));
    chk("ign.hold", 64'(bus.result), 64'(14));
    run_op("ign.next", 2'd0, 32'd1, 32'd1);

    // async reset in the middle of an operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.a     = 32'd7;
    bus.b     = 32'd6;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ar.busy", 64'(bus.busy), 64'(0));
    chk("ar.done", 64'(bus.done), 64'(0));
    chk("ar.res", 64'(bus.result), 64'(0));
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    chk("ar.nodone", 64'(ndone), 64'(0));
    run_op("ar.after", 2'd0, 32'd7, 32'd6);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 5))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 255);
        2:       x = 32'd0;
        default: y = $urandom;
      endcase
      if (i == 0) y = $urandom;
      run_op($sformatf("rnd%0d", i), o, x, y);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iter_muldiv.md
Name: iter_muldiv

Overview:
Iterative unsigned multiply/divide unit for the execute stage.
- Takes two 32-bit operands and an op code, then runs a shift-add (multiply) or restoring (divide) iteration, one bit per cycle.
- Presents a 32-bit result with a one-cycle done pulse.
- done drives the enable of the downstream 32-bit result register (data_in <= result) directly.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request; sampled only in IDLE.
op  input  2  00 MULU_LO, 01 MULU_HI, 10 DIVU (quotient), 11 REMU (remainder).
a  input  WIDTH  multiplicand / dividend; captured on accepted start.
b  input  WIDTH  multiplier / divisor; captured on accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse, high in DONE; use as downstream register enable.
result  output  WIDTH  selected result; valid when done is high, held until next accepted start.
div_by_zero  output  1  high with done when op is DIVU/REMU and captured b==0; held with result.

Behaviour:
- Reset (rst=1, any time including mid-operation):
  - state=IDLE, counter=0, busy=0, done=0, result=0, div_by_zero=0.
  - Internal accumulators are cleared.
  - The in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start=1: capture a, b, op; clear accumulator; counter=0.
  - RUN: one iteration per clock; counter++. After the WIDTH-th iteration -> DONE.
  - DONE -> IDLE unconditionally after one cycle.
- Latency: start sampled at edge k gives busy=1 for cycles k..k+WIDTH-1, done=1 for exactly the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- start is ignored in RUN and DONE; no queuing. Operand or op changes after capture have no effect.
- Multiply:
  - 2*WIDTH-bit product via shift-add on the captured operands.
  - MULU_LO selects product[WIDTH-1:0]; MULU_HI selects product[2*WIDTH-1:WIDTH].
  - No overflow flag.
- Divide (restoring, WIDTH-bit quotient, WIDTH+1-bit partial remainder):
  - DIVU selects the quotient; REMU selects the remainder.
  - b==0: quotient = all ones, remainder = a, div_by_zero=1. This falls out of the algorithm; same latency.
- result and div_by_zero update only on the DONE entry edge. They hold otherwise, including through the next RUN.
- div_by_zero is 0 for multiply ops.

Optional Feature:
Macro EARLY_OUT_EN.
- Defined: on an accepted start, if (op is MUL* and (a==0 or b==0)) or (op is DIV/REM and b==0), the FSM goes IDLE -> DONE directly.
  - done pulses in the cycle after edge k; busy never asserts.
  - Results are identical to the full-latency path.
- Undefined: all operations take the full WIDTH+1 cycles; no zero-detect logic is synthesised.

Decomposition:
- Shared package/include muldiv_defs:
  - op encodings OP_MULU_LO/OP_MULU_HI/OP_DIVU/OP_REMU.
  - FSM state encodings S_IDLE/S_RUN/S_DONE.
- Sub-module iter_muldiv_ctrl (FSM + iteration counter, outputs busy/done/step/load) is natural.
- The datapath (accumulators, shift/subtract) stays in iter_muldiv.

Test Plan:
1. MULU_LO a=7, b=6, start 1 cycle -> busy 32 cycles, done pulse at edge k+32 (cycle 33 after start), result=0x0000002A, div_by_zero=0. Downstream register loads 42 on done.
2. a=b=0xFFFFFFFF: MULU_HI -> 0xFFFFFFFE; MULU_LO -> 0x00000001.
3. a=100, b=7: DIVU -> 0x0000000E; REMU -> 0x00000002. Also a=5, b=9: DIVU -> 0, REMU -> 5.
4. DIVU a=0x1234, b=0 -> result=0xFFFFFFFF, div_by_zero=1. REMU same operands -> result=0x00001234, div_by_zero=1. With EARLY_OUT_EN: done 1 cycle after start.
5. Start DIVU 100/7, then assert start with a=1, b=1 at cycles 5 and at the DONE cycle -> both ignored, result=14. Next IDLE start accepted normally.
6. Start MULU_LO 7*6, assert rst at cycle 10 for 1 cycle -> busy=0, done=0, result=0 immediately (async). No done pulse follows. New start after release completes with the correct value.
